// File: rtl/mesh_term_src.sv
// ============================================================================
// Module   : mesh_term_src
// Purpose  : Per-terminal packet source for one mesh terminal input port.
//            A FWFT FIFO with overflow tracking and an optional head-stall
//            watchdog, enabled with `define MESH_SRC_WDOG_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mesh_term_src #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [pckg_sz-1:0]            din,
    input  logic                          clr,
    input  logic                          popin,
    output logic [pckg_sz-1:0]            data_out_i_in,
    output logic                          pndng_i_in,
    output logic                          full,
    output logic [$clog2(fifo_depth):0]   count,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    output logic                          stall
);

    localparam int              c_PW    = $clog2(fifo_depth);
    localparam int              c_CW    = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(fifo_depth);
    localparam logic [c_PW-1:0] c_LAST  = c_PW'(fifo_depth - 1);

    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_PW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic               r_pndng;
    logic               r_full;
    logic               r_overflow;
    logic [15:0]        r_drop_cnt;

    logic               w_pop;
    logic               w_push_ok;
    logic               w_drop;
    logic [c_CW-1:0]    w_cnt_nxt;

    function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
        f_inc = (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_pop     = popin && (r_count != '0);
    assign w_push_ok = push && ((r_count != c_DEPTH) || popin);
    assign w_drop    = push && !w_push_ok;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_push_ok && !w_pop)
            w_cnt_nxt = r_count + 1'b1;
        else if (!w_push_ok && w_pop)
            w_cnt_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < fifo_depth; i++)
                r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pndng  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= f_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= f_inc(r_rd_ptr);
            r_count <= w_cnt_nxt;
            r_pndng <= (w_cnt_nxt != '0);
            r_full  <= (w_cnt_nxt == c_DEPTH);
        end
    end

    // clr outranks a drop on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

`ifdef MESH_SRC_WDOG_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2
    } wd_state_t;

    localparam logic [15:0] c_WD_LAST = 16'(TIMEOUT - 1);

    wd_state_t   r_state;
    logic [15:0] r_wd_cnt;
    logic        r_stall;

    // The FSM tracks the next occupancy so WAIT starts on the same edge that
    // makes the FIFO nonempty; STALL then lands exactly TIMEOUT edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_wd_cnt <= '0;
            r_stall  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cnt_nxt != '0) begin
                        r_state  <= S_WAIT;
                        r_wd_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_pop) begin
                        r_wd_cnt <= '0;
                        r_state  <= (w_cnt_nxt == '0) ? S_IDLE : S_WAIT;
                    end else if (r_wd_cnt == c_WD_LAST) begin
                        r_state <= S_STALL;
                        r_stall <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    end
                end
                S_STALL: begin
                    if (w_pop) begin
                        r_wd_cnt <= '0;
                        r_state  <= (w_cnt_nxt == '0) ? S_IDLE : S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (clr)
                r_stall <= 1'b0;
        end
    end

    assign stall = r_stall;
`else
    if (TIMEOUT < 2) begin : g_timeout_unused
    end

    assign stall = 1'b0;
`endif

    assign data_out_i_in = r_mem[r_rd_ptr];
    assign pndng_i_in    = r_pndng;
    assign full          = r_full;
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign drop_cnt      = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mesh_term_src.sv
// Testbench for mesh_term_src: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
`default_nettype none

module tb_mesh_term_src;

    localparam int PSZ   = 40;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             push = 1'b0;
    logic [PSZ-1:0]   din = '0;
    logic             clr = 1'b0;
    logic             popin = 1'b0;
    logic [PSZ-1:0]   data_out_i_in;
    logic             pndng_i_in;
    logic             full;
    logic [2:0]       count;
    logic             overflow;
    logic [15:0]      drop_cnt;
    logic             stall;

    int checks = 0;
    int failures = 0;

    mesh_term_src #(.pckg_sz(PSZ), .fifo_depth(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .push(push), .din(din), .clr(clr),
        .popin(popin), .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in),
        .full(full), .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
        .stall(stall)
    );

    always #5 clk = ~clk;

`ifdef MESH_SRC_WDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    // ---------------- reference model ----------------
    logic [PSZ-1:0] mq[$];
    bit             m_ovf;
    int             m_dc;
    int             m_idle;
    bit             m_stall;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_dc = 0; m_idle = 0; m_stall = 0;
    endtask

    task automatic model_step(input bit p, input logic [PSZ-1:0] d, input bit po, input bit c);
        int  n;
        bit  pop_ok, push_ok;
        n       = mq.size();
        pop_ok  = po && (n > 0);
        push_ok = p && ((n < DEPTH) || po);
        if (pop_ok) void'(mq.pop_front());
        if (push_ok) mq.push_back(d);
        if (c) begin
            m_ovf = 0; m_dc = 0;
        end else if (p && !push_ok) begin
            m_ovf = 1;
            if (m_dc < 65535) m_dc++;
        end
        // consecutive edges the head has been waiting without being taken
        if (n == 0 && mq.size() > 0) m_idle = 0;
        else if (n > 0 && pop_ok)    m_idle = 0;
        else if (n > 0)              m_idle++;
        if (WD_EN && n > 0 && !pop_ok && m_idle == TO) m_stall = 1;
        if (c) m_stall = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".pndng"}, 64'(pndng_i_in), 64'(mq.size() > 0));
        chk({tag, ".full"}, 64'(full), 64'(mq.size() == DEPTH));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_dc));
        chk({tag, ".stall"}, 64'(stall), 64'(m_stall));
        if (mq.size() > 0) chk({tag, ".head"}, 64'(data_out_i_in), 64'(mq[0]));
    endtask

    // Drive inputs at negedge, let one rising edge pass, advance the model.
    task automatic drive(input bit p, input logic [PSZ-1:0] d, input bit po, input bit c);
        @(negedge clk);
        push = p; din = d; popin = po; clr = c;
        @(posedge clk);
        model_step(p, d, po, c);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; push = 0; popin = 0; clr = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit             p;
        logic [PSZ-1:0] d;
        bit             po;
        bit             c;
        int             e_cnt;
        logic [PSZ-1:0] e_head;
        bit             e_full;
        bit             e_ovf;
        int             e_dc;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(bit p, logic [PSZ-1:0] d, bit po, bit c,
                                int ec, logic [PSZ-1:0] eh, bit ef, bit eo, int ed);
        vec_t v;
        v.p = p; v.d = d; v.po = po; v.c = c;
        v.e_cnt = ec; v.e_head = eh; v.e_full = ef; v.e_ovf = eo; v.e_dc = ed;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(1, 40'hA1, 0, 0, 1, 40'hA1, 0, 0, 0);
        tbl[1]  = mk(1, 40'hA2, 0, 0, 2, 40'hA1, 0, 0, 0);
        tbl[2]  = mk(1, 40'hA3, 0, 0, 3, 40'hA1, 0, 0, 0);
        tbl[3]  = mk(1, 40'hA4, 0, 0, 4, 40'hA1, 1, 0, 0);
        tbl[4]  = mk(1, 40'hB5, 0, 0, 4, 40'hA1, 1, 1, 1);
        tbl[5]  = mk(1, 40'hB5, 1, 0, 4, 40'hA2, 1, 1, 1);
        tbl[6]  = mk(0, 40'h0,  1, 0, 3, 40'hA3, 0, 1, 1);
        tbl[7]  = mk(0, 40'h0,  1, 0, 2, 40'hA4, 0, 1, 1);
        tbl[8]  = mk(0, 40'h0,  1, 0, 1, 40'hB5, 0, 1, 1);
        tbl[9]  = mk(0, 40'h0,  1, 0, 0, 40'h0,  0, 1, 1);
        tbl[10] = mk(0, 40'h0,  1, 0, 0, 40'h0,  0, 1, 1);
        tbl[11] = mk(1, 40'hC1, 1, 0, 1, 40'hC1, 0, 1, 1);
        tbl[12] = mk(0, 40'h0,  0, 1, 1, 40'hC1, 0, 0, 0);
        tbl[13] = mk(0, 40'h0,  1, 0, 0, 40'h0,  0, 0, 0);
    end

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        #1;
        chk("reset.count", 64'(count), 64'd0);
        chk("reset.pndng", 64'(pndng_i_in), 64'd0);
        chk("reset.data", 64'(data_out_i_in), 64'd0);
        chk("reset.drop_cnt", 64'(drop_cnt), 64'd0);
        chk("reset.stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // directed table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].p, tbl[i].d, tbl[i].po, tbl[i].c);
            chk($sformatf("vec%0d.count", i), 64'(count), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.pndng", i), 64'(pndng_i_in), 64'(tbl[i].e_cnt != 0));
            chk($sformatf("vec%0d.full", i), 64'(full), 64'(tbl[i].e_full));
            chk($sformatf("vec%0d.overflow", i), 64'(overflow), 64'(tbl[i].e_ovf));
            chk($sformatf("vec%0d.drop_cnt", i), 64'(drop_cnt), 64'(tbl[i].e_dc));
            chk($sformatf("vec%0d.stall", i), 64'(stall), 64'd0);
            if (tbl[i].e_cnt != 0)
                chk($sformatf("vec%0d.head", i), 64'(data_out_i_in), 64'(tbl[i].e_head));
        end

        // asynchronous reset mid-stream
        do_reset();
        drive(1, 40'h11, 0, 0);
        drive(1, 40'h12, 0, 0);
        drive(1, 40'h13, 0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.pndng", 64'(pndng_i_in), 64'd0);
        chk("arst.full", 64'(full), 64'd0);
        chk("arst.data", 64'(data_out_i_in), 64'd0);
        push = 0; popin = 0; clr = 0;
        @(negedge clk);
        reset = 1'b1;
        drive(0, 40'h0, 0, 0);
        chk("arst_rel.count", 64'(count), 64'd0);
        chk("arst_rel.pndng", 64'(pndng_i_in), 64'd0);

        // watchdog: stall exactly TO edges after the FIFO becomes nonempty
        do_reset();
        drive(1, 40'h77, 0, 0);
        for (int k = 1; k <= TO; k++) begin
            drive(0, 40'h0, 0, 0);
            chk($sformatf("wd.edge%0d.stall", k), 64'(stall), 64'(WD_EN && (k == TO)));
        end
        drive(0, 40'h0, 1, 0);
        chk("wd.pop.count", 64'(count), 64'd0);
        chk("wd.pop.stall_sticky", 64'(stall), 64'(WD_EN));
        drive(0, 40'h0, 0, 1);
        chk("wd.clr.stall", 64'(stall), 64'd0);

        // drop counter saturation, then clr racing a drop
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1, 40'(i), 0, 0);
        @(negedge clk);
        push = 1; popin = 0; clr = 0; din = 40'hEE;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("sat.drop_cnt", 64'(drop_cnt), 64'hFFFF);
        chk("sat.overflow", 64'(overflow), 64'd1);
        chk("sat.count", 64'(count), 64'd4);
        chk("sat.head", 64'(data_out_i_in), 64'h0);
        clr = 1;
        @(posedge clk);
        #1;
        chk("satclr.drop_cnt", 64'(drop_cnt), 64'd0);
        chk("satclr.overflow", 64'(overflow), 64'd0);
        chk("satclr.count", 64'(count), 64'd4);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int pop_pct;
            pop_pct = (i < 1500) ? 50 : 12;
            drive($urandom_range(99) < 60, {$urandom, $urandom} & 40'hFF_FFFF_FFFF,
                  $urandom_range(99) < pop_pct, $urandom_range(99) < 3);
            chk_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mesh_term_src.md
# mesh_term_src

Per-terminal packet source feeding one mesh terminal input port. It buffers packets from the host/test side in a first-word-fall-through FIFO and presents the head on `data_out_i_in`/`pndng_i_in`. It advances on the router's `popin` strobe. It also flags overflow, counts dropped packets, and can flag a stalled terminal.

## Interface
- `pckg_sz`, 40: packet width in bits.
- `fifo_depth`, 4: FIFO entries; any integer ≥ 2.
- `TIMEOUT`, 64: watchdog threshold in cycles; range 2..65535.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `push`  in  1  — write strobe from the host side.
- `din`  in  pckg_sz  — packet written when `push`=1.
- `clr`  in  1  — synchronous clear of `overflow`, `drop_cnt` and `stall`.
- `popin`  in  1  — router consumed the head packet.
- `data_out_i_in`  out  pckg_sz  — head packet.
- `pndng_i_in`  out  1  — FIFO not empty.
- `full`  out  1  — count == fifo_depth.
- `count`  out  $clog2(fifo_depth)+1  — current occupancy.
- `overflow`  out  1  — sticky: a push was dropped.
- `drop_cnt`  out  16  — dropped pushes; saturates at 16'hFFFF.
- `stall`  out  1  — sticky watchdog flag.

## Operation
- Storage is a circular buffer of fifo_depth entries with write pointer, read pointer and occupancy counter.
  - Pointers wrap from fifo_depth-1 to 0; non-power-of-two depths are legal.
- `data_out_i_in` is always mem[rd_ptr]. Its value is don't-care while `pndng_i_in`=0.
- Push handling:
  - Push is accepted when count < fifo_depth, or when count == fifo_depth and `popin`=1 in the same cycle.
  - Otherwise the push is dropped: `overflow` is set and `drop_cnt` increments, saturating.
- `popin` while count==0 is ignored: no pointer or count change, no error.
- Simultaneous accepted push and valid pop: both pointers advance and count is unchanged.
- Push into an empty FIFO with `popin`=1 in the same cycle: the pop is ignored and count becomes 1.
- `clr` has priority over a same-cycle overflow event: after that edge, `overflow`=0 and `drop_cnt`=0. FIFO contents are unaffected.
- Watchdog FSM states:
  - IDLE: count==0. Goes to WAIT when count becomes nonzero.
  - WAIT: `pndng_i_in`=1; wd_cnt increments each cycle without `popin`.
    - `popin` clears wd_cnt to 0 and stays in WAIT, or goes to IDLE if the FIFO empties.
    - wd_cnt reaching TIMEOUT-1 with no `popin` goes to STALL and sets `stall`.
  - STALL: `stall` stays asserted. `popin` clears wd_cnt and returns to WAIT or IDLE.
  - `stall` stays set until `clr` or reset.

## Timing
- Reset (async assert, `reset`=0) forces:
  - pointers, count, wd_cnt = 0; FSM = IDLE;
  - `pndng_i_in`=0, `full`=0, `count`=0, `overflow`=0, `drop_cnt`=0, `stall`=0;
  - `data_out_i_in`=0 (memory is cleared).
- Reset deassertion is used synchronously. The first edge with `reset`=1 may accept a push.
- Reset mid-operation discards all buffered packets immediately.
- Latency:
  - push at edge N gives `pndng_i_in`=1 and valid `data_out_i_in` after edge N (registered);
  - `popin` sampled at edge N presents the next head after edge N.
- `popin` is a one-cycle strobe per packet. Holding it high for k cycles pops k packets, bounded by occupancy.
- `full`, `count` and `pndng_i_in` are registered and update on the same edge as the pointers.
- Stall timing: with the head pending and `popin` held at 0, `stall` asserts after exactly TIMEOUT edges following the edge that made the FIFO nonempty.

## Configuration
- `MESH_SRC_WDOG_EN` defined: watchdog FSM, wd_cnt and the `stall` logic are compiled in as above.
- Not defined: no FSM and no counter; `stall` is tied to 0 and `clr` affects only `overflow`/`drop_cnt`.

## Test plan
- Reset with `reset`=0 mid-stream after 3 pushes → all outputs 0 immediately; after release `count`=0 and `pndng_i_in`=0.
- fifo_depth=4: push 40'hA1..A4 on 4 consecutive edges, no pop → `full`=1 and `count`=4. Pop 4 times → outputs A1,A2,A3,A4 in order, then `pndng_i_in`=0.
- Full FIFO, push 40'hB5 with `popin`=0 → dropped: `overflow`=1, `drop_cnt`=1, count stays 4. Repeat with `popin`=1 → B5 accepted, count stays 4.
- Empty FIFO, push 40'hC1 and `popin`=1 on the same edge → count=1 and head=C1. `popin` alone on an empty FIFO → no change.
- `MESH_SRC_WDOG_EN`, TIMEOUT=8: push one packet, `popin`=0 → `stall`=1 after exactly 8 edges. `popin` → FSM to IDLE with `stall` still 1; `clr` → `stall`=0.
- Force 70000 overflows → `drop_cnt` saturates at 16'hFFFF; `clr` with a simultaneous drop → `drop_cnt`=0 and `overflow`=0.
